// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite engines.
//   state_t : mover FSM states
//   dir_t   : direction request latched on a go-accept
//   XW/YW   : coordinate widths for the 160x120 playfield
package sprite_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam logic [2:0] BG_DEFAULT = 3'b000;

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_MOVE, S_DRAW} state_t;

  typedef struct packed {
    logic left;
    logic right;
    logic up;
    logic down;
  } dir_t;
endpackage

// File: rtl/sprite_scan.sv
// Raster counter over an SPR_W x SPR_H sprite box.
//   clk, resetn : clock, async active-low reset
//   i_clr       : synchronous clear to (0,0), wins over i_en
//   i_en        : advance one pixel in raster order (wraps after last)
//   o_px, o_py  : current pixel offset inside the box
//   o_last      : current pixel is the bottom-right one
module sprite_scan #(
  parameter int SPR_W = 4,
  parameter int SPR_H = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_clr,
  input  logic       i_en,
  output logic [3:0] o_px,
  output logic [3:0] o_py,
  output logic       o_last
);
  localparam logic [3:0] PX_MAX = 4'(SPR_W - 1);
  localparam logic [3:0] PY_MAX = 4'(SPR_H - 1);

  logic [3:0] r_px, r_py;
  logic       w_px_wrap;

  assign w_px_wrap = (r_px == PX_MAX);
  assign o_last    = w_px_wrap && (r_py == PY_MAX);
  assign o_px      = r_px;
  assign o_py      = r_py;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_px <= '0;
      r_py <= '0;
    end else if (i_clr) begin
      r_px <= '0;
      r_py <= '0;
    end else if (i_en) begin
      if (w_px_wrap) begin
        r_px <= '0;
        r_py <= (r_py == PY_MAX) ? 4'd0 : r_py + 4'd1;
      end else begin
        r_px <= r_px + 4'd1;
      end
    end
  end
endmodule

// File: rtl/sprite_mover.sv
// Player sprite engine: holds the sprite origin, and on each accepted go
// erases the sprite, moves the origin (saturating within bounds, or jumping
// to spawn if a respawn is pending), then redraws it one pixel per cycle.
//   clk, resetn              : clock, async active-low reset
//   go                       : move request, accepted only in IDLE
//   left/right/up/down       : directions, sampled with go
//   respawn                  : pulse, latched until the next MOVE
//   colour                   : sprite colour, sampled with go
//   x, y, colour_out, plot   : pixel stream to the VGA adapter
//   x_ori, y_ori             : current origin
//   busy, done, goal         : status
module sprite_mover
  import sprite_pkg::*;
#(
  parameter int         SPR_W     = 4,
  parameter int         SPR_H     = 4,
  parameter int         STEP      = 1,
  parameter int         X_MIN     = 26,
  parameter int         X_MAX     = 133,
  parameter int         Y_MIN     = 21,
  parameter int         Y_MAX     = 102,
  parameter int         X_SPAWN   = 80,
  parameter int         Y_SPAWN   = 102,
  parameter int         Y_GOAL    = 21,
  parameter logic [2:0] BG_COLOUR = BG_DEFAULT
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          go,
  input  logic          left,
  input  logic          right,
  input  logic          up,
  input  logic          down,
  input  logic          respawn,
  input  logic [2:0]    colour,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [2:0]    colour_out,
  output logic          plot,
  output logic [XW-1:0] x_ori,
  output logic [YW-1:0] y_ori,
  output logic          busy,
  output logic          done,
  output logic          goal
);
  localparam logic [8:0]    STEP9   = 9'(STEP);
  localparam logic [8:0]    XMIN9   = 9'(X_MIN);
  localparam logic [8:0]    XMAX9   = 9'(X_MAX);
  localparam logic [8:0]    YMIN9   = 9'(Y_MIN);
  localparam logic [8:0]    YMAX9   = 9'(Y_MAX);
  localparam logic [XW-1:0] XMIN_C  = XW'(X_MIN);
  localparam logic [XW-1:0] XMAX_C  = XW'(X_MAX);
  localparam logic [YW-1:0] YMIN_C  = YW'(Y_MIN);
  localparam logic [YW-1:0] YMAX_C  = YW'(Y_MAX);
  localparam logic [XW-1:0] XSPN_C  = XW'(X_SPAWN);
  localparam logic [YW-1:0] YSPN_C  = YW'(Y_SPAWN);
  localparam logic [YW-1:0] YGOAL_C = YW'(Y_GOAL);

  state_t        r_state;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [2:0]    r_col;
  dir_t          r_dir;
  logic          r_resp;
  logic          r_done;

  logic [3:0]    w_px, w_py;
  logic          w_last, w_plot, w_clr;
  logic [8:0]    w_x9, w_y9;
  logic [XW-1:0] w_xn;
  logic [YW-1:0] w_yn;

  assign w_plot = (r_state == S_ERASE) || (r_state == S_DRAW);
  assign w_clr  = (r_state == S_IDLE)  || (r_state == S_MOVE);

  sprite_scan #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .i_clr  (w_clr),
    .i_en   (w_plot),
    .o_px   (w_px),
    .o_py   (w_py),
    .o_last (w_last)
  );

  // 9-bit headroom so a step past either screen edge compares correctly
  // before saturating; the saturated result always fits the narrow width.
  assign w_x9 = {1'b0, r_x};
  assign w_y9 = {2'b0, r_y};

  always_comb begin
    w_xn = r_x;
    if (r_dir.left)
      w_xn = (w_x9 < XMIN9 + STEP9) ? XMIN_C : XW'(w_x9 - STEP9);
    else if (r_dir.right)
      w_xn = (w_x9 + STEP9 > XMAX9) ? XMAX_C : XW'(w_x9 + STEP9);
  end

  always_comb begin
    w_yn = r_y;
    if (r_dir.up)
      w_yn = (w_y9 < YMIN9 + STEP9) ? YMIN_C : YW'(w_y9 - STEP9);
    else if (r_dir.down)
      w_yn = (w_y9 + STEP9 > YMAX9) ? YMAX_C : YW'(w_y9 + STEP9);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_DRAW;
      r_x     <= XSPN_C;
      r_y     <= YSPN_C;
      r_col   <= 3'b111;
      r_dir   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (go) begin
          r_dir   <= '{left: left, right: right, up: up, down: down};
          r_col   <= colour;
          r_state <= S_ERASE;
        end
        S_ERASE: if (w_last) r_state <= S_MOVE;
        S_MOVE: begin
          if (r_resp) begin
            r_x <= XSPN_C;
            r_y <= YSPN_C;
          end else begin
            r_x <= w_xn;
            r_y <= w_yn;
          end
          r_state <= S_DRAW;
        end
        S_DRAW: if (w_last) begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A pulse landing on the MOVE edge itself survives the clear and is
  // applied at the following MOVE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_resp <= 1'b0;
    else         r_resp <= respawn || (r_resp && (r_state != S_MOVE));
  end

  assign plot       = w_plot;
  assign x          = r_x + {4'b0, w_px};
  assign y          = r_y + {3'b0, w_py};
  assign colour_out = (r_state == S_ERASE) ? BG_COLOUR : r_col;
  assign x_ori      = r_x;
  assign y_ori      = r_y;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign goal       = (r_y <= YGOAL_C);
endmodule

// File: tb/tb_sprite_mover.sv
// Scoreboard bench for sprite_mover: the driver computes each move from the
// movement rules and queues the expected pixel stream; a negedge monitor pops
// and compares every plotted pixel.
module tb_sprite_mover;
  localparam int N = 16;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic go = 0, left = 0, right = 0, up = 0, down = 0, respawn = 0;
  logic [2:0] colour = 3'b000;
  logic [7:0] x, x_ori;
  logic [6:0] y, y_ori;
  logic [2:0] colour_out;
  logic plot, busy, done, goal;

  logic go2 = 0, left2 = 0, right2 = 0;
  logic [7:0] x2, x_ori2;
  logic [6:0] y2, y_ori2;
  logic [2:0] colour_out2;
  logic plot2, busy2, done2, goal2;

  always #5 clk = ~clk;

  sprite_mover dut (
    .clk(clk), .resetn(resetn), .go(go), .left(left), .right(right), .up(up),
    .down(down), .respawn(respawn), .colour(colour), .x(x), .y(y),
    .colour_out(colour_out), .plot(plot), .x_ori(x_ori), .y_ori(y_ori),
    .busy(busy), .done(done), .goal(goal));

  sprite_mover #(.STEP(3), .X_SPAWN(82)) dut2 (
    .clk(clk), .resetn(resetn), .go(go2), .left(left2), .right(right2), .up(1'b0),
    .down(1'b0), .respawn(1'b0), .colour(3'b001), .x(x2), .y(y2),
    .colour_out(colour_out2), .plot(plot2), .x_ori(x_ori2), .y_ori(y_ori2),
    .busy(busy2), .done(done2), .goal(goal2));

  typedef struct { int x; int y; int c; } pix_t;
  pix_t q[$];
  int errors = 0, checks = 0;
  int m_x = 80, m_y = 102, m2_x = 82;
  bit m_resp = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int mv(int o, bit neg, bit pos, int step, int lo, int hi);
    if (neg) return (o - step < lo) ? lo : o - step;
    if (pos) return (o + step > hi) ? hi : o + step;
    return o;
  endfunction

  task automatic push_box(input int ox, input int oy, input int c);
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) q.push_back('{ox + k, oy + r, c});
  endtask

  always @(negedge clk) begin : mon
    pix_t e;
    if (resetn && plot) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL pix_extra: got (%0d,%0d,%0d) expected none", x, y, colour_out);
      end else begin
        e = q.pop_front();
        if (int'(x) != e.x || int'(y) != e.y || int'(colour_out) != e.c) begin
          errors++;
          $display("FAIL pix: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                   x, y, colour_out, e.x, e.y, e.c);
        end
      end
    end
  end

  // Called #1 after a reference edge (n=0); steps edges, checks done/busy.
  task automatic run_window(input int exp_done, input int resp_at, input bit spam);
    int ndone = 0, first = -1, bad_busy = 0;
    for (int n = 0; n <= exp_done + 3; n++) begin
      respawn = (n == resp_at);
      go = spam && (n == N + 10 || n == N + 12);
      if (done) begin ndone++; if (first < 0) first = n; end
      if (busy != (n < exp_done)) bad_busy++;
      @(posedge clk); #1;
    end
    respawn = 0; go = 0;
    chk("done_count", ndone, 1);
    chk("done_cycle", first, exp_done);
    chk("busy_window", bad_busy, 0);
    chk("sb_drained", q.size(), 0);
    chk("x_ori", int'(x_ori), m_x);
    chk("y_ori", int'(y_ori), m_y);
    chk("goal", int'(goal), int'(m_y <= 21));
  endtask

  task automatic do_move(input bit l, r, u, d, input logic [2:0] c,
                         input int resp_at, input bit spam);
    int nx, ny;
    push_box(m_x, m_y, 0);
    if (m_resp || (resp_at >= 0 && resp_at <= N - 1)) begin
      nx = 80; ny = 102; m_resp = 0;
    end else begin
      nx = mv(m_x, l, r, 1, 26, 133);
      ny = mv(m_y, u, d, 1, 21, 102);
    end
    if (resp_at >= N) m_resp = 1;
    push_box(nx, ny, int'(c));
    m_x = nx; m_y = ny;
    @(posedge clk); #1;
    go = 1; left = l; right = r; up = u; down = d; colour = c;
    @(posedge clk); #1;
    go = 0;
    {left, right, up, down} = 4'($urandom);
    colour = 3'($urandom);
    run_window(2 * N + 1, resp_at, spam);
  endtask

  task automatic move2(input bit l, r);
    int first = -1;
    m2_x = mv(m2_x, l, r, 3, 26, 133);
    @(posedge clk); #1;
    go2 = 1; left2 = l; right2 = r;
    @(posedge clk); #1;
    go2 = 0; left2 = 0; right2 = 0;
    for (int n = 0; n <= 2 * N + 4; n++) begin
      if (done2 && first < 0) first = n;
      @(posedge clk); #1;
    end
    chk("s3_done_cycle", first, 2 * N + 1);
    chk("s3_x_ori", int'(x_ori2), m2_x);
  endtask

  initial begin
    #1 resetn = 0;
    #1;
    chk("rst_x_ori", int'(x_ori), 80);
    chk("rst_y_ori", int'(y_ori), 102);
    chk("rst_busy", int'(busy), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_goal", int'(goal), 0);
    push_box(80, 102, 7);
    repeat (3) @(posedge clk);
    #2 resetn = 1;
    run_window(N, -1, 0);

    do_move(0, 0, 1, 0, 3'b010, -1, 0);
    for (int i = 0; i < 20; i++)
      do_move($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), 3'($urandom), -1, 0);
    do_move(1, 1, 1, 1, 3'b101, -1, 0);
    do_move(0, 0, 0, 0, 3'b110, -1, 0);

    while (m_x > 26) do_move(1, 0, 0, 0, 3'b011, -1, 0);
    do_move(1, 0, 0, 0, 3'b011, -1, 0);
    chk("x_sat_min", int'(x_ori), 26);

    do_move(0, 1, 0, 0, 3'b100, 5, 0);

    while (m_y > 21) do_move(0, 0, 1, 0, 3'b001, -1, 0);
    do_move(0, 0, 1, 0, 3'b001, -1, 0);
    chk("goal_set", int'(goal), 1);

    do_move(0, 0, 0, 0, 3'b111, 20, 1);
    do_move(1, 0, 0, 0, 3'b010, -1, 0);
    chk("respawn_goal_drop", int'(goal), 0);

    do_move(0, 0, 1, 0, 3'b010, -1, 0);
    push_box(m_x, m_y, 0);
    @(posedge clk); #1;
    go = 1; up = 1; colour = 3'b110;
    @(posedge clk); #1;
    go = 0;
    repeat (5) @(posedge clk);
    #2 resetn = 0;
    #1;
    chk("async_x_ori", int'(x_ori), 80);
    chk("async_y_ori", int'(y_ori), 102);
    chk("async_busy", int'(busy), 1);
    q.delete();
    m_x = 80; m_y = 102; m_resp = 0;
    push_box(80, 102, 7);
    @(posedge clk); #2 resetn = 1;
    run_window(N, -1, 0);

    m2_x = 82;
    while (m2_x > 26) move2(1, 0);
    move2(1, 0);
    while (m2_x < 133) move2(0, 1);
    move2(0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
